// File: rtl/cordic_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// cordic_scheduler_pkg
// Shared settings for the CORDIC request scheduler: default sizing of the
// requester array, operand width, the RUN abort limit and the FSM state
// encoding used by the top level.
// ---------------------------------------------------------------------------
package cordic_scheduler_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_TIMEOUT    = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RUN   = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/cordic_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker. Searches the request vector starting at
// index ptr and wrapping around; the first asserted request wins.
//
// Ports
//   req   in  NUM_REQ  request vector
//   ptr   in  PTR_W    index with highest priority this cycle
//   grant out NUM_REQ  one-hot grant, all zero when no request
// ---------------------------------------------------------------------------
module rr_arbiter
    import cordic_scheduler_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    always_comb begin
        int  idx;
        logic found;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = (int'(ptr) + off) % NUM_REQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cordic_scheduler.sv
// ---------------------------------------------------------------------------
// cordic_scheduler
// Shares one CORDIC datapath among NUM_REQ requesters. A request is granted
// round-robin while idle, its operands are latched and handed to the datapath
// with a one-cycle start pulse, and the datapath results are returned through
// a valid/ready response channel tagged with the requester id.
//
// Optional feature: define CORDIC_SCHED_TIMEOUT_EN to build a RUN-cycle
// down-counter that aborts after TIMEOUT cycles without cdc_done and returns
// an error response (rsp_err=1, zero results). Without the macro RUN waits
// indefinitely and rsp_err is tied low.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   req_valid/req_ready  per-requester handshake (ready is one-hot or zero)
//   req_x, req_y         packed operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   cdc_start            one-cycle start pulse to the datapath
//   cdc_x, cdc_y         operands held for the datapath from ISSUE to RESP
//   cdc_done             datapath done (high when idle or finished)
//   cdc_mag, cdc_ang     datapath results
//   rsp_valid/rsp_ready  response handshake
//   rsp_id, rsp_mag, rsp_ang, rsp_err  response payload
//   busy                 high whenever not idle
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | arbitrate; accept one request and latch its operands
// ST_ISSUE | cdc_start high for this single cycle
// ST_RUN   | wait for cdc_done (first cycle ignored) or abort counter
// ST_RESP  | hold response until rsp_ready
// ---------------------------------------------------------------------------
module cordic_scheduler
    import cordic_scheduler_pkg::*;
#(
    parameter  int NUM_REQ    = DEF_NUM_REQ,
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int TIMEOUT    = DEF_TIMEOUT,
    localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_x,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_y,
    output logic                          cdc_start,
    output logic [DATA_WIDTH-1:0]         cdc_x,
    output logic [DATA_WIDTH-1:0]         cdc_y,
    input  logic                          cdc_done,
    input  logic [DATA_WIDTH-1:0]         cdc_mag,
    input  logic [DATA_WIDTH-1:0]         cdc_ang,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_mag,
    output logic [DATA_WIDTH-1:0]         rsp_ang,
    output logic                          rsp_err,
    output logic                          busy
);

    state_t                state_q,     state_d;
    logic [ID_W-1:0]       rr_ptr_q,    rr_ptr_d;
    logic [ID_W-1:0]       id_q,        id_d;
    logic                  cdc_start_q, cdc_start_d;
    logic [DATA_WIDTH-1:0] cdc_x_q,     cdc_x_d;
    logic [DATA_WIDTH-1:0] cdc_y_q,     cdc_y_d;
    logic                  first_run_q, first_run_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_mag_q,   rsp_mag_d;
    logic [DATA_WIDTH-1:0] rsp_ang_q,   rsp_ang_d;

`ifdef CORDIC_SCHED_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             rsp_err_q, rsp_err_d;
`else
    // TIMEOUT only matters when the abort counter is built.
    localparam int unused_timeout = TIMEOUT;
`endif

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    gnt_id;
    logic [ID_W-1:0]    ptr_next;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (ID_W)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (grant)
    );

    always_comb begin
        gnt_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) gnt_id = ID_W'(i);
        end
    end

    assign ptr_next = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;

    // Ready is only offered while idle; gated by rst so nothing is accepted
    // during reset even though it is a combinational path.
    assign req_ready = (state_q == ST_IDLE && !rst) ? grant : '0;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        cdc_start_d = 1'b0;
        cdc_x_d     = cdc_x_q;
        cdc_y_d     = cdc_y_q;
        first_run_d = first_run_q;
        rsp_valid_d = rsp_valid_q;
        rsp_mag_d   = rsp_mag_q;
        rsp_ang_d   = rsp_ang_q;
`ifdef CORDIC_SCHED_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        rsp_err_d   = rsp_err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    id_d        = gnt_id;
                    cdc_x_d     = req_x[gnt_id*DATA_WIDTH +: DATA_WIDTH];
                    cdc_y_d     = req_y[gnt_id*DATA_WIDTH +: DATA_WIDTH];
                    cdc_start_d = 1'b1;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                first_run_d = 1'b1;
`ifdef CORDIC_SCHED_TIMEOUT_EN
                tmo_cnt_d   = TMO_W'(TIMEOUT - 1);
`endif
                state_d     = ST_RUN;
            end
            ST_RUN: begin
                first_run_d = 1'b0;
                // The datapath's done is still high from its previous idle
                // period on the first RUN cycle, so it is not trusted there.
                if (!first_run_q && cdc_done) begin
                    rsp_mag_d   = cdc_mag;
                    rsp_ang_d   = cdc_ang;
                    rsp_valid_d = 1'b1;
`ifdef CORDIC_SCHED_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
`endif
                    state_d     = ST_RESP;
                end
`ifdef CORDIC_SCHED_TIMEOUT_EN
                else if (tmo_cnt_q == '0) begin
                    rsp_mag_d   = '0;
                    rsp_ang_d   = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - 1'b1;
                end
`endif
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rr_ptr_d    = ptr_next;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            cdc_start_q <= 1'b0;
            cdc_x_q     <= '0;
            cdc_y_q     <= '0;
            first_run_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_mag_q   <= '0;
            rsp_ang_q   <= '0;
`ifdef CORDIC_SCHED_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            cdc_start_q <= cdc_start_d;
            cdc_x_q     <= cdc_x_d;
            cdc_y_q     <= cdc_y_d;
            first_run_q <= first_run_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_mag_q   <= rsp_mag_d;
            rsp_ang_q   <= rsp_ang_d;
`ifdef CORDIC_SCHED_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign cdc_start = cdc_start_q;
    assign cdc_x     = cdc_x_q;
    assign cdc_y     = cdc_y_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_mag   = rsp_mag_q;
    assign rsp_ang   = rsp_ang_q;
    assign busy      = (state_q != ST_IDLE);
`ifdef CORDIC_SCHED_TIMEOUT_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_cordic_scheduler.sv
// ---------------------------------------------------------------------------
// tb_cordic_scheduler
// Self-checking bench for cordic_scheduler with a behavioural datapath
// (done low for dp_n cycles after start, mag=x+y, ang=x-y) and a reference
// model of round-robin order and response latency.
// ---------------------------------------------------------------------------
module tb_cordic_scheduler;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int TO = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_ready;
    logic [NR*DW-1:0]  req_x = '0;
    logic [NR*DW-1:0]  req_y = '0;
    logic              cdc_start;
    logic [DW-1:0]     cdc_x, cdc_y;
    logic              cdc_done;
    logic [DW-1:0]     cdc_mag, cdc_ang;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [1:0]        rsp_id;
    logic [DW-1:0]     rsp_mag, rsp_ang;
    logic              rsp_err;
    logic              busy;

    cordic_scheduler #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .cdc_start (cdc_start),
        .cdc_x     (cdc_x),
        .cdc_y     (cdc_y),
        .cdc_done  (cdc_done),
        .cdc_mag   (cdc_mag),
        .cdc_ang   (cdc_ang),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_mag   (rsp_mag),
        .rsp_ang   (rsp_ang),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Behavioural datapath, reset by the same rst.
    int      dp_n    = 1;
    bit      dp_hold = 1'b0;
    int      dp_cnt;
    logic [DW-1:0] dp_mag, dp_ang;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_cnt <= 0;
            dp_mag <= '0;
            dp_ang <= '0;
        end else if (cdc_start) begin
            dp_cnt <= dp_n;
            dp_mag <= cdc_x + cdc_y;
            dp_ang <= cdc_x - cdc_y;
        end else if (dp_cnt > 0) begin
            dp_cnt <= dp_cnt - 1;
        end
    end

    assign cdc_done = (dp_cnt == 0) && !dp_hold;
    assign cdc_mag  = dp_mag;
    assign cdc_ang  = dp_ang;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference model state: next round-robin priority index.
    int ptr_model = 0;

    function automatic int rr_pick(input logic [NR-1:0] m, input int p);
        for (int k = 0; k < NR; k++) begin
            if (m[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    // Runs one complete transaction; called at a negedge with the DUT idle.
    task automatic run_txn(input logic [NR-1:0] mask, input int n, input int bp,
                           input bit expect_tmo, input bit fix34);
        logic [DW-1:0] xs [NR];
        logic [DW-1:0] ys [NR];
        logic [DW-1:0] emag, eang;
        logic [NR-1:0] gbit;
        int g, lat, limit, exp_lat, starts;

        for (int i = 0; i < NR; i++) begin
            xs[i] = DW'($urandom);
            ys[i] = DW'($urandom);
        end
        if (fix34) begin
            xs[0] = 16'd3;
            ys[0] = 16'd4;
        end
        req_x     = {xs[3], xs[2], xs[1], xs[0]};
        req_y     = {ys[3], ys[2], ys[1], ys[0]};
        dp_n      = n;
        rsp_ready = 1'b0;
        req_valid = mask;
        g    = rr_pick(mask, ptr_model);
        gbit = NR'(1) << g;
        #1;
        chk("req_ready_grant", 64'(req_ready), 64'(gbit));

        @(negedge clk);
        req_valid = mask & ~gbit;
        exp_lat   = expect_tmo ? (TO + 2) : (n + 3);
        limit     = exp_lat + 10;
        lat       = 1;
        starts    = 0;
        while (rsp_valid !== 1'b1 && lat < limit) begin
            #1;
            chk("req_ready_busy", 64'(req_ready), 64'(0));
            chk("cdc_x_hold", 64'(cdc_x), 64'(xs[g]));
            chk("cdc_y_hold", 64'(cdc_y), 64'(ys[g]));
            if (cdc_start) starts++;
            rsp_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        rsp_ready = 1'b0;
        chk("start_count", 64'(starts), 64'(1));
        chk("rsp_latency", 64'(lat), 64'(exp_lat));

        emag = expect_tmo ? '0 : DW'(xs[g] + ys[g]);
        eang = expect_tmo ? '0 : DW'(xs[g] - ys[g]);
        chk("rsp_id", 64'(rsp_id), 64'(g));
        chk("rsp_mag", 64'(rsp_mag), 64'(emag));
        chk("rsp_ang", 64'(rsp_ang), 64'(eang));
        chk("rsp_err", 64'(rsp_err), 64'(expect_tmo));

        for (int b = 0; b < bp; b++) begin
            req_valid = '1;
            #1;
            chk("bp_req_ready", 64'(req_ready), 64'(0));
            chk("bp_rsp_valid", 64'(rsp_valid), 64'(1));
            chk("bp_rsp_id", 64'(rsp_id), 64'(g));
            chk("bp_rsp_mag", 64'(rsp_mag), 64'(emag));
            chk("bp_rsp_ang", 64'(rsp_ang), 64'(eang));
            chk("bp_cdc_start", 64'(cdc_start), 64'(0));
            @(negedge clk);
        end

        req_valid = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post_hs_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("post_hs_busy", 64'(busy), 64'(0));
        ptr_model = (g + 1) % NR;
    endtask

    initial begin
        int cnt;

        // Reset values
        #2;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_cdc_start", 64'(cdc_start), 64'(0));
        chk("rst_cdc_xy", 64'({cdc_x, cdc_y}), 64'(0));
        chk("rst_rsp_payload", 64'({rsp_id, rsp_mag, rsp_ang, rsp_err}), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Contention from reset: all requesters valid, five rounds.
        for (int r = 0; r < 5; r++) begin
            chk("contention_order", 64'(rr_pick(4'b1111, ptr_model)), 64'(r % NR));
            run_txn(4'b1111, int'($urandom_range(1, 12)), 0, 1'b0, 1'b0);
        end

        // Single request x=3, y=4, done low 16 cycles.
        run_txn(4'b0001, 16, 0, 1'b0, 1'b1);

        // Backpressure for 10 cycles.
        run_txn(4'b0011, 5, 10, 1'b0, 1'b0);

        // Randomized traffic.
        for (int t = 0; t < 25; t++) begin
            run_txn(NR'($urandom_range(1, 15)), int'($urandom_range(1, 20)),
                    int'($urandom_range(0, 3)), 1'b0, 1'b0);
        end

        // Move the pointer off zero, then reset in the middle of RUN.
        run_txn(4'b0010, 4, 0, 1'b0, 1'b0);
        dp_n      = 20;
        req_valid = 4'b0100;
        #1;
        chk("mid_rst_grant", 64'(req_ready), 64'(4'b0100));
        @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);
        chk("mid_rst_busy_before", 64'(busy), 64'(1));
        req_valid = 4'b1111;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_cdc", 64'({cdc_start, cdc_x, cdc_y}), 64'(0));
        chk("mid_rst_rsp", 64'({rsp_valid, rsp_id, rsp_mag, rsp_ang, rsp_err}), 64'(0));
        chk("mid_rst_req_ready", 64'(req_ready), 64'(0));
        @(negedge clk);
        rst       = 1'b0;
        req_valid = '0;
        ptr_model = 0;
        cnt = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (rsp_valid) cnt++;
        end
        chk("mid_rst_no_rsp", 64'(cnt), 64'(0));
        run_txn(4'b1111, 6, 1, 1'b0, 1'b0);

        // Datapath never finishes.
        dp_hold = 1'b1;
`ifdef CORDIC_SCHED_TIMEOUT_EN
        run_txn(4'b0100, 3, 2, 1'b1, 1'b0);
        dp_hold = 1'b0;
`else
        req_valid = 4'b0001;
        @(negedge clk);
        req_valid = '0;
        cnt = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (rsp_valid) cnt++;
        end
        chk("no_tmo_no_rsp", 64'(cnt), 64'(0));
        chk("no_tmo_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        dp_hold   = 1'b0;
        ptr_model = 0;
        @(negedge clk);
        run_txn(4'b1000, 5, 0, 1'b0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cordic_scheduler.md
CORDIC_SCHEDULER -- requirements
Module: cordic_scheduler

Interface
REQ-001 The block SHALL use one clock, clk, and reset rst, which is asynchronous and active-high.
REQ-002 Parameter NUM_REQ, 4: number of requesters.
REQ-003 Parameter DATA_WIDTH, 16: operand/result width, two's complement.
REQ-004 Parameter TIMEOUT, 64: maximum RUN cycles before abort.
REQ-005 Port clk  in  1  clock.
REQ-006 Port rst  in  1  async active-high reset.
REQ-007 Port req_valid  in  NUM_REQ  per-requester request.
REQ-008 Port req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
REQ-009 Port req_x, req_y  in  NUM_REQ*DATA_WIDTH each  packed operands, requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 Port cdc_start  out  1  one-cycle start pulse to the CORDIC datapath.
REQ-011 Port cdc_x, cdc_y  out  DATA_WIDTH each  latched operands to the datapath.
REQ-012 Port cdc_done  in  1  datapath done: high when idle or final, low while computing.
REQ-013 Port cdc_mag, cdc_ang  in  DATA_WIDTH each  datapath results.
REQ-014 Port rsp_valid  out  1;  rsp_ready  in  1  response handshake.
REQ-015 Port rsp_id  out  clog2(NUM_REQ);  rsp_mag, rsp_ang  out  DATA_WIDTH;  rsp_err  out  1.
REQ-016 Port busy  out  1  high in any state other than IDLE.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, RUN, RESP.
REQ-018 IDLE: if any req_valid, the block SHALL grant round-robin starting at pointer rr_ptr, assert req_ready[grant] combinationally that cycle, latch operands and grant id, and go to ISSUE.
REQ-019 ISSUE: cdc_start SHALL be 1 for exactly this cycle, then RUN.
REQ-020 RUN: the block SHALL ignore cdc_done on the first RUN cycle and thereafter, on cdc_done==1, capture cdc_mag/cdc_ang and go to RESP.
REQ-021 RESP: rsp_valid=1 with rsp_id/rsp_mag/rsp_ang/rsp_err stable until rsp_ready; on the handshake cycle go to IDLE and set rr_ptr = grant+1 modulo NUM_REQ.
REQ-022 req_ready SHALL be 0 outside IDLE; requesters hold req_valid and operands until req_ready.
REQ-023 Requester deasserting req_valid before grant SHALL simply lose arbitration, without error.
REQ-024 With a datapath whose done is low for N cycles after start, rsp_valid SHALL rise N+3 cycles after the accept cycle.
REQ-025 cdc_x/cdc_y SHALL stay constant from ISSUE through RESP.
REQ-026 rsp_ready while rsp_valid=0 SHALL be ignored.

Reset
REQ-027 On rst: state IDLE, rr_ptr 0, req_ready 0, cdc_start 0, cdc_x/cdc_y 0, rsp_valid 0, rsp_id/rsp_mag/rsp_ang/rsp_err 0, busy 0.
REQ-028 Reset mid-operation SHALL abort with no response; the datapath is reset by the same rst.

Configuration
REQ-029 Macro CORDIC_SCHED_TIMEOUT_EN defined: a RUN cycle counter SHALL, on reaching TIMEOUT without cdc_done, go to RESP with rsp_err=1 and rsp_mag=rsp_ang=0.
REQ-030 Macro undefined: no counter; rsp_err tied 0; RUN waits indefinitely.

Structure
REQ-031 State encoding, default NUM_REQ, DATA_WIDTH and TIMEOUT SHALL live in the shared settings header/package.
REQ-032 Round-robin selection SHALL be a combinational sub-module rr_arbiter (inputs req, ptr; output one-hot grant).

Verification
REQ-033 Single request: req_valid=0001, x=3, y=4, datapath model done low 16 cycles -> req_ready=0001 same cycle, one cdc_start, rsp_valid 19 cycles after accept, rsp_id=0, model results echoed.
REQ-034 Contention: req_valid=1111 held, 4 transactions -> rsp_id order 0,1,2,3; a 5th round starts at 0.
REQ-035 Backpressure: rsp_ready low 10 cycles in RESP -> rsp fields stable, req_ready stays 0, no new cdc_start.
REQ-036 Reset mid-RUN: rst pulse -> all outputs 0 next cycle, no response, next request granted from rr_ptr 0.
REQ-037 Timeout (macro defined, TIMEOUT=64): cdc_done held low -> rsp_valid, rsp_err=1, mag=ang=0 after 64 RUN cycles; macro undefined -> no response.
